// File: rtl/bram_arb_pkg.sv
// Shared types for the two-requester BRAM port arbiter: slot states and the request bundle.
// No logic; widths here are the single source for the request struct.
package bram_arb_pkg;

    localparam int ARB_DATA_W = 32;
    localparam int ARB_ADDR_W = 11;
    localparam int ARB_STRB_W = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_PEND  = 2'd1,
        SLOT_FULL  = 2'd2
    } slot_state_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_STRB_W-1:0] wstrb;
    } arb_req_t;

    // An all-zero byte-enable mask marks a read.
    function automatic logic req_is_write(input logic [ARB_STRB_W-1:0] wstrb);
        return |wstrb;
    endfunction

endpackage

// File: rtl/bram_arb_slot.sv
// Per-requester response slot: EMPTY -> PEND (BRAM access in flight) -> FULL (response held).
// Response appears 2 cycles after grant; held stable until rsp_ready, then re-grantable the same cycle.
module bram_arb_slot
    import bram_arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              grant,
    input  logic              is_write,
    input  logic              rsp_ready,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              eligible
);

    slot_state_t state;
    slot_state_t state_nxt;
    logic        wr_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SLOT_EMPTY;
            wr_flag   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                wr_flag <= is_write;
            end
            // bram_dout is only meaningful in the cycle after our own access.
            if (state == SLOT_PEND) begin
                rsp_rdata <= wr_flag ? '0 : bram_dout;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SLOT_EMPTY: begin
                if (grant) begin
                    state_nxt = SLOT_PEND;
                end
            end
            SLOT_PEND: begin
                state_nxt = SLOT_FULL;
            end
            SLOT_FULL: begin
                if (grant) begin
                    state_nxt = SLOT_PEND;
                end else if (rsp_ready) begin
                    state_nxt = SLOT_EMPTY;
                end
            end
            default: begin
                state_nxt = SLOT_EMPTY;
            end
        endcase
    end

    assign rsp_valid = (state == SLOT_FULL);
    assign eligible  = (state == SLOT_EMPTY) || ((state == SLOT_FULL) && rsp_ready);

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin share of one native_bram port between two valid/ready requesters.
// Grant is combinational, response 2 cycles later; a requester holding an unconsumed response is not granted.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int MEM_DATA_WIDTH  = ARB_DATA_W,
    parameter int BRAM_ADDR_WIDTH = ARB_ADDR_W
) (
    input  logic                        clka,
    input  logic                        rsta,

    input  logic                        r0_req_valid,
    output logic                        r0_req_ready,
    input  logic [BRAM_ADDR_WIDTH-1:0]  r0_req_addr,
    input  logic [MEM_DATA_WIDTH-1:0]   r0_req_wdata,
    input  logic [MEM_DATA_WIDTH/8-1:0] r0_req_wstrb,
    output logic                        r0_rsp_valid,
    input  logic                        r0_rsp_ready,
    output logic [MEM_DATA_WIDTH-1:0]   r0_rsp_rdata,

    input  logic                        r1_req_valid,
    output logic                        r1_req_ready,
    input  logic [BRAM_ADDR_WIDTH-1:0]  r1_req_addr,
    input  logic [MEM_DATA_WIDTH-1:0]   r1_req_wdata,
    input  logic [MEM_DATA_WIDTH/8-1:0] r1_req_wstrb,
    output logic                        r1_rsp_valid,
    input  logic                        r1_rsp_ready,
    output logic [MEM_DATA_WIDTH-1:0]   r1_rsp_rdata,

    output logic [BRAM_ADDR_WIDTH-1:0]  bram_addr,
    output logic [MEM_DATA_WIDTH-1:0]   bram_din,
    output logic                        bram_en,
    output logic [MEM_DATA_WIDTH/8-1:0] bram_we,
    input  logic [MEM_DATA_WIDTH-1:0]   bram_dout
);

    // The request struct is sized by the package, so the parameters must agree with it.
    if (MEM_DATA_WIDTH != ARB_DATA_W || BRAM_ADDR_WIDTH != ARB_ADDR_W) begin : g_width_chk
        $error("bram_port_arbiter widths must match bram_arb_pkg");
    end

    arb_req_t req0;
    arb_req_t req1;
    arb_req_t win;

    logic elig0;
    logic elig1;
    logic cand0;
    logic cand1;
    logic grant0;
    logic grant1;
    logic ptr;

    assign req0 = '{addr: r0_req_addr, wdata: r0_req_wdata, wstrb: r0_req_wstrb};
    assign req1 = '{addr: r1_req_addr, wdata: r1_req_wdata, wstrb: r1_req_wstrb};

    // Nothing is accepted while reset is held, so a request cannot slip into a slot being cleared.
    always_comb begin
        cand0  = r0_req_valid && elig0 && !rsta;
        cand1  = r1_req_valid && elig1 && !rsta;
        grant0 = cand0 && (!cand1 || (ptr == 1'b0));
        grant1 = cand1 && (!cand0 || (ptr == 1'b1));
    end

    assign r0_req_ready = grant0;
    assign r1_req_ready = grant1;

    // Pointer names the preferred requester; it moves to whoever lost (or was idle) this grant.
    always_ff @(posedge clka) begin
        if (rsta) begin
            ptr <= 1'b0;
        end else if (grant0 || grant1) begin
            ptr <= grant0;
        end
    end

    always_comb begin
        win = '0;
        if (grant0) begin
            win = req0;
        end else if (grant1) begin
            win = req1;
        end
        bram_en   = grant0 || grant1;
        bram_addr = win.addr;
        bram_din  = win.wdata;
        bram_we   = win.wstrb;
    end

    bram_arb_slot #(
        .DATA_W (MEM_DATA_WIDTH)
    ) u_slot0 (
        .clk       (clka),
        .rst       (rsta),
        .grant     (grant0),
        .is_write  (req_is_write(req0.wstrb)),
        .rsp_ready (r0_rsp_ready),
        .bram_dout (bram_dout),
        .rsp_valid (r0_rsp_valid),
        .rsp_rdata (r0_rsp_rdata),
        .eligible  (elig0)
    );

    bram_arb_slot #(
        .DATA_W (MEM_DATA_WIDTH)
    ) u_slot1 (
        .clk       (clka),
        .rst       (rsta),
        .grant     (grant1),
        .is_write  (req_is_write(req1.wstrb)),
        .rsp_ready (r1_rsp_ready),
        .bram_dout (bram_dout),
        .rsp_valid (r1_rsp_valid),
        .rsp_rdata (r1_rsp_rdata),
        .eligible  (elig1)
    );

endmodule
